fifo_lvl: RTL and testbench
===========================

// Module: fifo_lvl
// PURPOSE
//  Parametrised synchronous show-ahead FIFO for the UART TX/RX paths and any other byte/word stream buffering.
//  Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
//  Corrects simultaneous read/write at the empty and full boundaries.
//  Sits between the UART rx/tx cores and the host/interface logic.
// PARAMETERS
//  B      8   data word width, bits
//  W      4   address width; depth = 2**W words
//  AF_LVL 12  almost_full asserted when count >= AF_LVL (1 .. 2**W)
//  AE_LVL 2   almost_empty asserted when count <= AE_LVL (0 .. 2**W-1)
// PORTS
//  clk          in  1    clock, rising edge
//  reset        in  1    asynchronous, active-high
//  clr          in  1    synchronous flush, active-high
//  wr           in  1    write request
//  rd           in  1    read request; pops the word currently on r_data
//  w_data       in  B    write data
//  r_data       out B    head-of-queue word; valid only while empty=0
//  full         out 1    count == 2**W
//  empty        out 1    count == 0
//  almost_full  out 1    count >= AF_LVL
//  almost_empty out 1    count <= AE_LVL
//  count        out W+1  occupancy, 0 .. 2**W
//  overflow     out 1    sticky: write attempted while full and not popped in the same cycle
//  underflow    out 1    sticky: read attempted while empty
// BEHAVIOUR
//  - Reset values:
//    - w_ptr=0, r_ptr=0, count=0
//    - empty=1, full=0, almost_empty=1, almost_full=0
//    - overflow=0, underflow=0
//    - memory contents are not reset.
//  - All status outputs are registered and reflect the state after the last clock edge; no combinational path from wr/rd to any flag.
//  - r_data is combinational: r_data = mem[r_ptr], i.e. first-word-fall-through.
//    - After a write to an empty FIFO, the word appears on r_data and empty drops 1 cycle later.
//  - Accepted write:
//    - mem[w_ptr] <= w_data, then w_ptr+1.
//    - Pointers are W bits and wrap modulo 2**W.
//  - Accepted read: r_ptr+1.
//  - Operation table, evaluated on {wr,rd} at each edge when clr=0:
//    - 00: hold.
//    - 10, not full: write; count+1.
//    - 10, full: write dropped; overflow<=1.
//    - 01, not empty: read; count-1.
//    - 01, empty: read ignored; underflow<=1.
//    - 11, not empty and not full: write and read; count unchanged.
//    - 11, empty: write only; count becomes 1; read ignored; underflow<=1.
//    - 11, full: read and write both performed; count unchanged.
//      The write lands in the slot freed this cycle (w_ptr == r_ptr); overflow unaffected.
//  - Next-state flags are derived from count_next:
//    - full  = (count_next == 2**W)
//    - empty = (count_next == 0)
//    - almost_full, almost_empty compared against AF_LVL and AE_LVL.
//  - count arithmetic is W+1 bits unsigned and never leaves the range 0 .. 2**W.
//  - clr=1 has priority over wr/rd:
//    - pointers, count and flags return to their reset values, including overflow/underflow.
//    - any wr/rd in that cycle is discarded; memory is untouched.
//  - overflow/underflow are cleared only by reset or clr.
//  - reset asserted mid-operation: state returns to reset values immediately (async); in-flight data is lost.
// STRUCTURE
//  - Shared include fifo_defs.vh: default B, W, AF_LVL, AE_LVL, and the wr/rd opcode localparams (NOP, RD, WR, RW).
//  - Sub-module fifo_regfile:
//    - 2**W x B register array.
//    - Synchronous write on wr_en.
//    - Asynchronous read at r_addr.
//  - fifo_lvl holds the pointer, count and flag control logic only.
// TESTING  (B=8, W=2 -> depth 4, AF_LVL=3, AE_LVL=1)
//  1. Reset, then hold idle -> empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0.
//  2. Write 0x11,0x22,0x33,0x44 on consecutive cycles:
//     - count steps 1,2,3,4.
//     - almost_empty drops after the 2nd write; almost_full rises after the 3rd; full after the 4th.
//     - r_data=0x11 from the cycle after the 1st write.
//  3. Full, then write 0x55 -> dropped, overflow=1, count=4.
//     Then 4 reads -> r_data sequence 0x11,0x22,0x33,0x44; empty=1 after the 4th read.
//  4. Empty, then rd=1 -> underflow=1, count=0.
//     wr=rd=1 with 0xA5 on empty -> count=1, r_data=0xA5.
//     wr=rd=1 with 0xB6 while full -> count stays 4, overflow unchanged, 0xB6 is read last.
//  5. Wrap-around: 10 write/read pairs of 0x00..0x09, pushed and popped with an occupancy of 2 maintained -> data out in order, no flag glitches.
//  6. Load 3 words with overflow and underflow set, then clr=1 with wr=1 in the same cycle -> all reset values, the write is discarded.
//     Assert reset mid-burst -> same reset values immediately.

Source files
------------

// File: rtl/fifo_lvl_pkg.sv
// fifo_lvl_pkg: default FIFO geometry, level thresholds and the {wr,rd} opcode encoding.
package fifo_lvl_pkg;

    localparam int B_DEF  = 8;
    localparam int W_DEF  = 4;
    localparam int AF_DEF = 12;
    localparam int AE_DEF = 2;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        RD  = 2'b01,
        WR  = 2'b10,
        RW  = 2'b11
    } op_e;

endpackage

// File: rtl/fifo_lvl_regfile.sv
// fifo_lvl_regfile: 2**W x B storage array, synchronous write, asynchronous read.
module fifo_lvl_regfile #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [W-1:0] w_addr,
    input  logic [W-1:0] r_addr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem_q [2**W];

    always_ff @(posedge clk)
        if (wr_en) mem_q[w_addr] <= w_data;

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: show-ahead FIFO with registered occupancy, level flags, sticky overflow/underflow and sync flush.
module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int B      = B_DEF,
    parameter int W      = W_DEF,
    parameter int AF_LVL = AF_DEF,
    parameter int AE_LVL = AE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH = (W+1)'(2**W);
    localparam logic [W:0] AF    = (W+1)'(AF_LVL);
    localparam logic [W:0] AE    = (W+1)'(AE_LVL);

    op_e          op;
    logic         we, re;
    logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         full_q, full_d, empty_q, empty_d;
    logic         af_q, af_d, ae_q, ae_d;
    logic         ovf_q, ovf_d, unf_q, unf_d;

    // A write while full is only accepted when a real pop frees the head slot in the same edge.
    always_comb begin
        op = op_e'({wr, rd});
        we = 1'b0;
        re = 1'b0;
        case (op)
            NOP: ;
            WR:  we = !full_q;
            RD:  re = !empty_q;
            RW: begin
                we = 1'b1;
                re = !empty_q;
            end
        endcase
    end

    always_comb begin
        w_ptr_d = clr ? '0 : w_ptr_q + W'(we);
        r_ptr_d = clr ? '0 : r_ptr_q + W'(re);
        count_d = clr ? '0 : count_q + (W+1)'(we) - (W+1)'(re);
        ovf_d   = !clr && (ovf_q || (op == WR && full_q));
        unf_d   = !clr && (unf_q || (rd && empty_q));
        full_d  = count_d == DEPTH;
        empty_d = count_d == '0;
        af_d    = count_d >= AF;
        ae_d    = count_d <= AE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_lvl_regfile #(.B(B), .W(W)) u_regfile (
        .clk    (clk),
        .wr_en  (we && !clr),
        .w_addr (w_ptr_q),
        .r_addr (r_ptr_q),
        .w_data (w_data),
        .r_data (r_data)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed and random stimulus against a queue-based FIFO model, depth 4, AF=3, AE=1.
module tb_fifo_lvl;

    localparam int B = 8, W = 2, DEPTH = 4, AF = 3, AE = 1;

    logic         clk = 1'b0, reset = 1'b1, clr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [B-1:0] w_data = '0, r_data;
    logic         full, empty, almost_full, almost_empty, overflow, underflow;
    logic [W:0]   count;

    int   checks = 0, failures = 0;
    bit   chk_en = 1'b0;
    logic [B-1:0] mq [$];
    bit   m_ovf = 1'b0, m_unf = 1'b0;

    fifo_lvl #(.B(B), .W(W), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .w_data       (w_data),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue; a pop happens before the push so a full-FIFO read+write fits.
    always @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit do_rd, do_wr;
            do_rd = rd && mq.size() > 0;
            do_wr = wr && (mq.size() < DEPTH || do_rd);
            if (wr && !do_wr) m_ovf = 1'b1;
            if (rd && mq.size() == 0) m_unf = 1'b1;
            if (do_rd) void'(mq.pop_front());
            if (do_wr) mq.push_back(w_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W+6:0] act, exp;
            int n;
            n   = mq.size();
            act = {count, empty, full, almost_full, almost_empty, overflow, underflow};
            exp = {(W+1)'(n), n == 0, n == DEPTH, n >= AF, n <= AE, m_ovf, m_unf};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL status t=%0t got cnt/e/f/af/ae/ov/un=%b expected %b", $time, act, exp);
            end
            if (n > 0) begin
                checks++;
                if (r_data !== mq[0]) begin
                    failures++;
                    $display("FAIL r_data t=%0t got %h expected %h", $time, r_data, mq[0]);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [B-1:0] d, input logic c);
        wr = w;
        rd = r;
        w_data = d;
        clr = c;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        clr = 1'b0;
    endtask

    task automatic lit_reset_state(input string tag);
        lit({tag, "_count"}, 32'(count), 0);
        lit({tag, "_flags"}, {empty, full, almost_empty, almost_full, overflow, underflow}, 6'b101000);
    endtask

    initial begin
        logic [7:0] seq [4];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        cyc(0, 0, 0, 0);
        lit_reset_state("idle");

        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, seq[i], 0);
            lit("wr_count", 32'(count), i + 1);
            lit("wr_rdata", 32'(r_data), 32'h11);
        end
        lit("full_flags", {full, almost_full, almost_empty, empty}, 4'b1100);

        cyc(1, 0, 8'h55, 0);
        lit("ovf_set", 32'(overflow), 1);
        lit("ovf_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            lit("rd_data", 32'(r_data), 32'(seq[i]));
            cyc(0, 1, 0, 0);
        end
        lit("drained_empty", 32'(empty), 1);

        cyc(0, 1, 0, 0);
        lit("unf_set", 32'(underflow), 1);
        lit("unf_count", 32'(count), 0);
        cyc(1, 1, 8'hA5, 0);
        lit("rw_empty_count", 32'(count), 1);
        lit("rw_empty_rdata", 32'(r_data), 32'hA5);

        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
        cyc(1, 1, 8'hB6, 0);
        lit("rw_full_count", 32'(count), 4);
        lit("rw_full_ovf", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        lit("b6_last", 32'(r_data), 32'hB6);
        cyc(0, 1, 0, 0);

        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h01, 0);
        for (int i = 2; i < 10; i++) begin
            lit("wrap_head", 32'(r_data), 32'(i - 2));
            cyc(1, 1, 8'(i), 0);
            lit("wrap_count", 32'(count), 2);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h70 + i), 0);
        cyc(0, 1, 0, 0);
        lit("pre_clr", {32'(count), overflow, underflow}, {32'd3, 2'b11});
        cyc(1, 0, 8'hEE, 1);
        lit_reset_state("clr");

        cyc(1, 0, 8'h81, 0);
        cyc(1, 0, 8'h82, 0);
        wr = 1'b1;
        w_data = 8'h83;
        reset = 1'b1;
        #1;
        lit_reset_state("async_rst");
        @(negedge clk);
        #1;
        wr = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 8'($urandom), 1'($urandom_range(0, 63) == 0));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
